fft_stream_adapter: RTL and testbench

Streaming front/back end for the parallel-array FFT core. Collects N complex samples from a valid/ready stream into a frame buffer and presents them in parallel to the core. Pulses start, waits for done with a timeout, then drains the result as a valid/ready stream. Generalises the fixed 64-point, forward-only load/start/read sequence to parametric N and width, with per-frame FFT/IFFT mode, zero-padding of short frames and error flags.

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_buf.sv | 31 +++
 rtl/fft_stream_adapter.sv | 146 ++++++++++++++
 tb/tb_fft_stream_adapter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, states and defaults for the FFT stream adapter
package fft_pkg;

    localparam int DEFAULT_N = 64;
    localparam int DEFAULT_W = 16;

    // One complex sample at the default component width
    typedef struct packed {
        logic signed [DEFAULT_W-1:0] re;
        logic signed [DEFAULT_W-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } adapter_state_e;

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - N-entry complex frame register with one write port, zero-fill and parallel load
module fft_frame_buf #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    localparam int LOG2N   = $clog2(N_POINTS)
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic                       wr_zero,
    input  logic [LOG2N-1:0]           wr_addr,
    input  logic [DATA_W-1:0]          wr_re,
    input  logic [DATA_W-1:0]          wr_im,
    input  logic                       load,
    input  logic [N_POINTS*DATA_W-1:0] load_re,
    input  logic [N_POINTS*DATA_W-1:0] load_im,
    output logic [N_POINTS*DATA_W-1:0] rd_re,
    output logic [N_POINTS*DATA_W-1:0] rd_im
);

    // Whole-frame load wins over a single-entry write; the storage is the read-out itself
    always_ff @(posedge clk) begin
        if (load) begin
            rd_re <= load_re;
            rd_im <= load_im;
        end else if (wr_en) begin
            rd_re[wr_addr*DATA_W +: DATA_W] <= wr_zero ? '0 : wr_re;
            rd_im[wr_addr*DATA_W +: DATA_W] <= wr_zero ? '0 : wr_im;
        end
    end

endmodule

// File: rtl/fft_stream_adapter.sv
// rtl/fft_stream_adapter.sv - valid/ready stream wrapper around a parallel-array FFT core
module fft_stream_adapter
    import fft_pkg::*;
#(
    parameter int N_POINTS = DEFAULT_N,
    parameter int DATA_W   = DEFAULT_W,
    parameter int TIMEOUT  = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_re,
    input  logic [DATA_W-1:0]          s_im,
    input  logic                       s_last,
    input  logic                       s_ifft,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_re,
    output logic [DATA_W-1:0]          m_im,
    output logic                       m_last,
    output logic [N_POINTS*DATA_W-1:0] fft_in_re,
    output logic [N_POINTS*DATA_W-1:0] fft_in_im,
    output logic                       fft_start,
    output logic                       fft_ifft,
    input  logic                       fft_done,
    input  logic [N_POINTS*DATA_W-1:0] fft_out_re,
    input  logic [N_POINTS*DATA_W-1:0] fft_out_im,
    output logic                       err_short,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int LOG2N = $clog2(N_POINTS);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N_POINTS - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);

    adapter_state_e state_q, state_d;
    logic [LOG2N-1:0] idx, oidx;
    logic [TW-1:0]    tcnt;
    logic             mode;
    logic             in_we, in_zero, out_load;
    logic [N_POINTS*DATA_W-1:0] out_re, out_im;

    // Next-state and buffer strobes; the output buffer loads on the done edge itself
    // because the core is free to change its result bus right after done
    always_comb begin
        state_d  = state_q;
        in_we    = 1'b0;
        in_zero  = 1'b0;
        out_load = 1'b0;
        case (state_q)
            S_FILL: begin
                if (s_valid) begin
                    in_we = 1'b1;
                    if (idx == IDX_LAST) state_d = S_START;
                    else if (s_last)     state_d = S_PAD;
                end
            end
            S_PAD: begin
                in_we   = 1'b1;
                in_zero = 1'b1;
                if (idx == IDX_LAST) state_d = S_START;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (fft_done) begin
                    out_load = 1'b1;
                    state_d  = S_CAPTURE;
                end else if (tcnt == T_LAST) begin
                    state_d = S_FILL;
                end
            end
            S_CAPTURE: state_d = S_DRAIN;
            S_DRAIN: begin
                if (m_ready && oidx == IDX_LAST) state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FILL;
        else      state_q <= state_d;
    end

    // Indices, wait counter, frame mode and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx         <= '0;
            oidx        <= '0;
            tcnt        <= '0;
            mode        <= 1'b0;
            err_short   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (in_we) idx <= idx + 1'b1;
            if (state_q == S_FILL && s_valid && idx == '0) mode <= s_ifft;
            if (state_q == S_FILL && s_valid && s_last && idx != IDX_LAST) err_short <= 1'b1;
            if (state_q == S_WAIT) tcnt <= tcnt + 1'b1;
            else                   tcnt <= '0;
            if (state_q == S_WAIT && !fft_done && tcnt == T_LAST) err_timeout <= 1'b1;
            if (state_q == S_DRAIN && m_ready) oidx <= oidx + 1'b1;
        end
    end

    fft_frame_buf #(.N_POINTS(N_POINTS), .DATA_W(DATA_W)) u_in_buf (
        .clk     (clk),
        .wr_en   (in_we),
        .wr_zero (in_zero),
        .wr_addr (idx),
        .wr_re   (s_re),
        .wr_im   (s_im),
        .load    (1'b0),
        .load_re ('0),
        .load_im ('0),
        .rd_re   (fft_in_re),
        .rd_im   (fft_in_im)
    );

    fft_frame_buf #(.N_POINTS(N_POINTS), .DATA_W(DATA_W)) u_out_buf (
        .clk     (clk),
        .wr_en   (1'b0),
        .wr_zero (1'b0),
        .wr_addr ('0),
        .wr_re   ('0),
        .wr_im   ('0),
        .load    (out_load),
        .load_re (fft_out_re),
        .load_im (fft_out_im),
        .rd_re   (out_re),
        .rd_im   (out_im)
    );

    assign s_ready   = (state_q == S_FILL);
    assign fft_start = (state_q == S_START);
    assign fft_ifft  = mode;
    assign m_valid   = (state_q == S_DRAIN);
    assign m_last    = (state_q == S_DRAIN) && (oidx == IDX_LAST);
    assign m_re      = out_re[oidx*DATA_W +: DATA_W];
    assign m_im      = out_im[oidx*DATA_W +: DATA_W];
    assign busy      = !(state_q == S_FILL && idx == '0);

endmodule

// File: tb/tb_fft_stream_adapter.sv
// tb/tb_fft_stream_adapter.sv - self-checking bench for fft_stream_adapter
module tb_fft_stream_adapter;

    localparam int N   = 64;
    localparam int W   = 16;
    localparam int TMO = 16;

    logic clk, rst;
    logic s_valid, s_ready, s_last, s_ifft;
    logic [W-1:0] s_re, s_im;
    logic m_valid, m_ready, m_last;
    logic [W-1:0] m_re, m_im;
    logic [N*W-1:0] fft_in_re, fft_in_im, fft_out_re, fft_out_im;
    logic fft_start, fft_ifft, fft_done;
    logic err_short, err_timeout, busy;

    fft_stream_adapter #(.N_POINTS(N), .DATA_W(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .s_last(s_last), .s_ifft(s_ifft),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_last(m_last),
        .fft_in_re(fft_in_re), .fft_in_im(fft_in_im), .fft_start(fft_start),
        .fft_ifft(fft_ifft), .fft_done(fft_done),
        .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
        .err_short(err_short), .err_timeout(err_timeout), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Expected padded frame: samples as sent, zeros beyond the short end
    logic [W-1:0] fr_re [N];
    logic [W-1:0] fr_im [N];
    logic exp_mode = 1'b0;
    logic core_en = 1'b1;
    logic stray_req = 1'b0;
    logic bp_en = 1'b0;
    int frames_done = 0;
    int out_cnt = 0;
    int starts = 0;
    int mv_cnt = 0;
    int stalls = 0;
    int cyc = 0;
    int done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat_re(input int p, input int i);
        return (p == 0) ? W'(i) : W'(i * 37 + p * 1000 + 5);
    endfunction

    function automatic logic [W-1:0] pat_im(input int p, input int i);
        return (p == 0) ? W'(-i) : W'(p * 4099 - i * 11);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream readiness: 1,0,0,1 cycling when backpressure is enabled
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                m_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Core model: identity transform, done 5 cycles after start, garbage on the bus otherwise
    initial begin
        logic [N*W-1:0] cap_re, cap_im;
        int cd;
        logic done_now;
        cap_re = '0;
        cap_im = '0;
        cd = 0;
        fft_done = 1'b0;
        fft_out_re = '1;
        fft_out_im = '1;
        forever begin
            @(negedge clk);
            done_now = 1'b0;
            if (!rst) begin
                cd = 0;
            end else if (fft_start) begin
                starts++;
                for (int i = 0; i < N; i++) begin
                    chk("fft_in_re", fft_in_re[i*W +: W], fr_re[i]);
                    chk("fft_in_im", fft_in_im[i*W +: W], fr_im[i]);
                end
                cap_re = fft_in_re;
                cap_im = fft_in_im;
                cd = core_en ? 5 : 0;
                chk("fft_ifft_start", fft_ifft, exp_mode);
            end else if (cd > 0) begin
                cd--;
                chk("fft_ifft_wait", fft_ifft, exp_mode);
                if (cd == 0) begin
                    done_now = 1'b1;
                    done_cyc = cyc;
                end
            end
            fft_done   = done_now || stray_req;
            fft_out_re = done_now ? cap_re : ~cap_re;
            fft_out_im = done_now ? cap_im : ~cap_im;
        end
    end

    // Output compare: sample order, m_last placement, hold under stall, done-to-first-beat latency
    initial begin
        logic prev_stall, prev_valid, pl;
        logic [W-1:0] pr, pi;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        pl = 1'b0;
        pr = '0;
        pi = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                out_cnt = 0;
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", m_valid, 1'b1);
                    chk("hold_re", m_re, pr);
                    chk("hold_im", m_im, pi);
                    chk("hold_last", m_last, pl);
                end
                chk("m_last_rule", m_last, m_valid && (out_cnt == N - 1));
                if (m_valid) begin
                    mv_cnt++;
                    if (!prev_valid) chk("done_latency", cyc - done_cyc, 2);
                    if (m_ready) begin
                        chk("m_re", m_re, fr_re[out_cnt]);
                        chk("m_im", m_im, fr_im[out_cnt]);
                        out_cnt++;
                        if (out_cnt == N) begin
                            out_cnt = 0;
                            frames_done++;
                        end
                    end else begin
                        stalls++;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_valid = m_valid;
                pr = m_re;
                pi = m_im;
                pl = m_last;
            end
        end
    end

    task automatic send_frame(input int n, input logic md, input int p);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = (i < n) ? pat_re(p, i) : '0;
            fr_im[i] = (i < n) ? pat_im(p, i) : '0;
        end
        exp_mode = md;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_re    = pat_re(p, i);
            s_im    = pat_im(p, i);
            s_last  = (i == n - 1);
            s_ifft  = (i == 0) ? md : !md;
            @(negedge clk);
            chk("s_ready_fill", s_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_ifft  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames_done < target && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("frame_complete", frames_done >= target, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_extra_beats", frames_done, target);
        chk("idle_m_valid", m_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int k, pad, mv_before, fd;
        rst = 1'b0;
        s_valid = 1'b0;
        s_re = '0;
        s_im = '0;
        s_last = 1'b0;
        s_ifft = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_fft_start", fft_start, 1'b0);
        chk("rst_fft_ifft", fft_ifft, 1'b0);
        chk("rst_err_short", err_short, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full frame re=i, im=-i
        send_frame(N, 1'b0, 0);
        wait_frames(1);
        chk("one_start", starts, 1);
        chk("lit_in_re63", fft_in_re[63*W +: W], 16'h003f);
        chk("lit_in_im1", fft_in_im[1*W +: W], 16'hffff);
        chk("no_short_full", err_short, 1'b0);

        // Short frame of 10 beats, zero padded
        send_frame(10, 1'b0, 1);
        @(negedge clk);
        chk("err_short_set", err_short, 1'b1);
        pad = 0;
        k = 0;
        while (!fft_start && k < 200) begin
            if (!s_ready) pad++;
            k++;
            @(negedge clk);
        end
        chk("pad_cycles", pad, 54);
        wait_frames(2);
        chk("lit_in_re9", fft_in_re[9*W +: W], 16'h053a);
        chk("lit_in_re10", fft_in_re[10*W +: W], 16'h0000);
        chk("lit_in_im63", fft_in_im[63*W +: W], 16'h0000);

        // Inverse mode taken from the first beat only, then forward with backpressure
        send_frame(N, 1'b1, 2);
        wait_frames(3);
        bp_en = 1'b1;
        send_frame(N, 1'b0, 3);
        wait_frames(4);
        bp_en = 1'b0;
        chk("stalls_seen", stalls > 0, 1'b1);
        chk("starts_4", starts, 4);

        // Timeout: core never answers
        core_en = 1'b0;
        mv_before = mv_cnt;
        send_frame(N, 1'b0, 4);
        @(negedge clk);
        chk("to_start", fft_start, 1'b1);
        k = 0;
        while (!s_ready && k < 100) begin
            @(negedge clk);
            k++;
            if (k == TMO) chk("to_flag_last_wait", err_timeout, 1'b0);
        end
        chk("to_cycles", k, TMO + 1);
        chk("to_err", err_timeout, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_short_sticky", err_short, 1'b1);
        // A done pulse while idle must be ignored
        @(posedge clk);
        #1;
        stray_req = 1'b1;
        @(posedge clk);
        #1;
        stray_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray_busy", busy, 1'b0);
        chk("stray_ready", s_ready, 1'b1);
        chk("to_no_output", mv_cnt, mv_before);
        core_en = 1'b1;

        // Reset in the middle of drain, then a clean frame
        send_frame(N, 1'b0, 5);
        k = 0;
        while (out_cnt != 20 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("reached_beat20", out_cnt, 20);
        fd = frames_done;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 1'b0);
        chk("mid_rst_s_ready", s_ready, 1'b1);
        chk("mid_rst_err_short", err_short, 1'b0);
        chk("mid_rst_err_timeout", err_timeout, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        send_frame(N, 1'b0, 6);
        wait_frames(fd + 1);
        chk("final_err_short", err_short, 1'b0);
        chk("final_err_timeout", err_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
